change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Payout side of the vending machine's change interface.
- Takes the vending FSM's one-cycle change code (01 = 5 rs, 10 = 10 rs) and adds it to an owed-coin balance.
- Pays the balance out one 5 rs coin at a time by pulsing a hopper solenoid and waiting for the coin-drop sensor. Timeouts are retried, and the block raises a sticky jam fault after too many retries.

Parameters:
- COIN_W, 4: width of the owed-coin counter, in 5 rs coins.
- FIRE_CYCLES, 4: cycles hopper_fire is held high per attempt.
- TIMEOUT, 64: cycles to wait for a coin_sense edge after firing ends.
- MAX_RETRY, 2: re-fires allowed per coin before jam.
- GAP_CYCLES, 2: settle cycles after each paid coin.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- change  input  2  change code from the vending FSM, valid for one cycle. 01 = +1 coin, 10 = +2 coins, 00/11 = none.
- coin_sense  input  1  hopper drop sensor, synchronous level.
- fault_clr  input  1  one-cycle pulse that clears jam.
- hopper_fire  output  1  solenoid drive, registered.
- paid  output  1  one-cycle pulse per coin confirmed.
- owed  output  COIN_W  current outstanding coin count.
- busy  output  1  high when state != IDLE or owed != 0.
- jam  output  1  sticky fault.
- overflow  output  1  sticky; a request was truncated by saturation.

Behaviour:
- Reset values (all registers synchronous to clk, reset synchronous active-high):
  - state = IDLE, owed = 0, all outputs 0, retry count = 0, timer = 0.
  - Sense history register = 1, so a sensor held high through reset produces no edge.
- Sensor edge: edge = coin_sense & ~sense_q.
- Edges are accepted only in FIRE or WAIT. Edges in IDLE, GAP or JAM are ignored.
- Owed arithmetic, evaluated every cycle:
  - next = owed + add − dec, where add ∈ {0,1,2} and dec ∈ {0,1}.
  - An accepted edge and a request in the same cycle are both applied.
  - The result saturates at 2^COIN_W−1. Saturation sets overflow.
- State machine:
  - IDLE:
    - If the registered owed != 0, go to FIRE and load the timer with FIRE_CYCLES.
    - Latency: change at cycle N → owed updates at N+1 → hopper_fire first high at N+2.
  - FIRE:
    - hopper_fire = 1.
    - On an accepted edge: dec = 1, paid = 1, retry = 0, hopper_fire drops next cycle, go to GAP.
    - When the timer expires: go to WAIT and load the timer with TIMEOUT.
  - WAIT:
    - hopper_fire = 0.
    - On an accepted edge: same actions as in FIRE, go to GAP.
    - On timeout with retry < MAX_RETRY: retry++, go to FIRE.
    - On timeout with retry == MAX_RETRY: go to JAM.
  - GAP:
    - Hold for GAP_CYCLES, then go to IDLE. IDLE re-fires if owed != 0.
  - JAM:
    - jam = 1. No firing.
    - Requests still accumulate into owed.
    - fault_clr: jam = 0, retry = 0, go to IDLE.
    - fault_clr outside JAM is ignored.
- Attempts per coin: at most 1 + MAX_RETRY fire pulses.
- overflow clears only on rst.
- Reset mid-operation: hopper_fire = 0 on the next edge and owed is discarded.

Optional Feature:
- Macro: CHANGE_DISPENSER_SPURIOUS_CNT_EN.
- When defined:
  - Adds output spurious_cnt[7:0].
  - The counter increments on each coin_sense edge that arrives in IDLE, GAP or JAM.
  - It saturates at 255 and resets to 0 on rst.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package change_pkg holds:
  - state enum: IDLE, FIRE, WAIT, GAP, JAM.
  - change code constants: CHG_NONE = 00, CHG_5 = 01, CHG_10 = 10.
  - COIN_VALUE = 5.
- Sub-module change_timer:
  - Loadable down-counter: load, value, expired.
  - Width is the clog2 of the maximum of FIRE_CYCLES, TIMEOUT and GAP_CYCLES.
  - Shared by the FIRE, WAIT and GAP states.

Test Plan:
1. change=10 at cycle 0; coin_sense high 3 cycles after each hopper_fire rise. Required: hopper_fire first rises at cycle 2; two paid pulses; owed goes 2→1→0; busy falls after the final GAP.
2. change=01; coin_sense held low. Required: exactly 3 fire pulses of 4 cycles, each followed by a 64-cycle wait; jam=1 and owed=1. Then pulse fault_clr and answer the sensor. Required: jam=0, one paid pulse, owed=0.
3. owed=1 in WAIT; change=01 in the same cycle as the accepted edge. Required: owed stays 1, paid=1, and the machine fires again after GAP.
4. owed=14 while jammed; change=10. Required: owed=15, overflow=1. Then a further change=01: owed stays 15 and overflow stays 1.
5. rst asserted on the third FIRE cycle. Required: hopper_fire=0, owed=0, jam=0 and busy=0 on the next edge. coin_sense held high through reset release produces no paid pulse.
6. change=11 and fault_clr pulses while IDLE. Required: no owed change and no output activity. With CHANGE_DISPENSER_SPURIOUS_CNT_EN defined, a coin_sense edge in IDLE gives spurious_cnt=1.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM states and change codes.
package change_pkg;

  typedef enum logic [2:0] {IDLE, FIRE, WAIT, GAP, JAM} state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  localparam int COIN_VALUE = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Number of 5 rs coins a change code asks for; 11 is treated as no request.
  function automatic logic [1:0] coins_of(input logic [1:0] code);
    case (code)
      CHG_NONE: coins_of = 2'd0;
      CHG_5:    coins_of = 2'd1;
      CHG_10:   coins_of = 2'd2;
      default:  coins_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_timer.sv
// Loadable down-counter shared by the FIRE, WAIT and GAP states.
// A load of N-1 makes expired assert on the Nth cycle after the load.
module change_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: accumulates owed 5 rs coins and pays them via hopper solenoid.
// Optional macro CHANGE_DISPENSER_SPURIOUS_CNT_EN adds a counter of ignored sensor edges.
//
// state | meaning
// IDLE  | nothing in flight; fires when owed != 0
// FIRE  | solenoid driven for FIRE_CYCLES
// WAIT  | solenoid off, waiting up to TIMEOUT for a drop
// GAP   | settle after a paid coin
// JAM   | retries exhausted; waits for fault_clr
module change_dispenser
  import change_pkg::*;
#(
  parameter int COIN_W      = 4,
  parameter int FIRE_CYCLES = 4,
  parameter int TIMEOUT     = 64,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        change,
  input  logic              coin_sense,
  input  logic              fault_clr,
  output logic              hopper_fire,
  output logic              paid,
  output logic [COIN_W-1:0] owed,
  output logic              busy,
  output logic              jam,
  output logic              overflow
`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
  ,
  output logic [7:0]        spurious_cnt
`endif
);

  localparam int TMAX = max3(FIRE_CYCLES, TIMEOUT, GAP_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] FIRE_LOAD    = TW'(FIRE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD     = TW'(GAP_CYCLES - 1);
  localparam logic [COIN_W+1:0] OWED_MAX = {2'b00, {COIN_W{1'b1}}};

  state_t          state;
  logic            sense_q;
  logic            sense_edge;
  logic            accept;
  logic [RW-1:0]   retry;
  logic            t_load;
  logic [TW-1:0]   t_val;
  logic            t_expired;
  logic [COIN_W+1:0] owed_sum;
  logic            owed_sat;

  assign sense_edge = coin_sense & ~sense_q;
  assign accept     = sense_edge && ((state == FIRE) || (state == WAIT));
  assign busy       = (state != IDLE) || (owed != '0);

  // Request and accepted drop in the same cycle both apply; only the total saturates.
  assign owed_sum = {2'b00, owed} + (COIN_W+2)'(coins_of(change)) - (COIN_W+2)'(accept);
  assign owed_sat = (owed_sum > OWED_MAX);

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      IDLE: begin
        if (owed != '0) begin
          t_load = 1'b1;
          t_val  = FIRE_LOAD;
        end
      end
      FIRE, WAIT: begin
        if (accept) begin
          t_load = 1'b1;
          t_val  = GAP_LOAD;
        end else if (t_expired) begin
          t_load = 1'b1;
          t_val  = (state == FIRE) ? TIMEOUT_LOAD : FIRE_LOAD;
        end
      end
      default: ;
    endcase
  end

  change_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .value   (t_val),
    .expired (t_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owed        <= '0;
      overflow    <= 1'b0;
      hopper_fire <= 1'b0;
      paid        <= 1'b0;
      jam         <= 1'b0;
      retry       <= '0;
      sense_q     <= 1'b1;
    end else begin
      sense_q <= coin_sense;
      paid    <= 1'b0;
      owed    <= owed_sat ? OWED_MAX[COIN_W-1:0] : owed_sum[COIN_W-1:0];
      if (owed_sat) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (owed != '0) begin
            state       <= FIRE;
            hopper_fire <= 1'b1;
          end
        end
        FIRE, WAIT: begin
          if (accept) begin
            paid        <= 1'b1;
            retry       <= '0;
            hopper_fire <= 1'b0;
            state       <= GAP;
          end else if (t_expired) begin
            if (state == FIRE) begin
              hopper_fire <= 1'b0;
              state       <= WAIT;
            end else if (retry == RW'(MAX_RETRY)) begin
              jam   <= 1'b1;
              state <= JAM;
            end else begin
              retry       <= retry + RW'(1);
              hopper_fire <= 1'b1;
              state       <= FIRE;
            end
          end
        end
        GAP: begin
          if (t_expired) state <= IDLE;
        end
        JAM: begin
          if (fault_clr) begin
            jam   <= 1'b0;
            retry <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      spurious_cnt <= '0;
    end else if (sense_edge && !((state == FIRE) || (state == WAIT)) && (spurious_cnt != 8'hFF)) begin
      spurious_cnt <= spurious_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, directed corner cases, random run vs model.
module tb_change_dispenser;

  localparam int COIN_W   = 4;
  localparam int OWED_TOP = (1 << COIN_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        change = 2'b00;
  logic              coin_sense = 1'b0;
  logic              fault_clr = 1'b0;
  logic              hopper_fire;
  logic              paid;
  logic [COIN_W-1:0] owed;
  logic              busy;
  logic              jam;
  logic              overflow;
`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
  logic [7:0]        spurious_cnt;
`endif

  change_dispenser #(
    .COIN_W(COIN_W), .FIRE_CYCLES(4), .TIMEOUT(64), .MAX_RETRY(2), .GAP_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .change      (change),
    .coin_sense  (coin_sense),
    .fault_clr   (fault_clr),
    .hopper_fire (hopper_fire),
    .paid        (paid),
    .owed        (owed),
    .busy        (busy),
    .jam         (jam),
    .overflow    (overflow)
`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
    ,
    .spurious_cnt(spurious_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    change = 2'b00;
    fault_clr = 1'b0;
    coin_sense = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_fire(input string name);
    for (int k = 0; k < 12 && !hopper_fire; k++) tick();
    chk(name, hopper_fire, 1);
  endtask

  task automatic wait_jam(input string name);
    for (int k = 0; k < 400 && !jam; k++) tick();
    chk(name, jam, 1);
  endtask

  typedef struct {
    logic [1:0] chg;
    logic       sense;
    logic       fclr;
    int         e_owed;
    int         e_fire;
    int         e_paid;
    int         e_busy;
  } vec_t;

  vec_t vecs[21];

  // random-phase state
  int   r_owed, r_ovf, exp_paid, add, dec;
  int   hi_cnt, target, misses;
  bit   answered;
  int   rises[$];
  int   falls[$];
  int   jam_at, fire_seen, paid_seen;
  logic prev_fire;

  initial begin
    // cycle-by-cycle: change=10, sensor answers on the 4th fire cycle, then idle noise
    vecs[0]  = '{2'b10, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 2, 0, 0, 1};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 2, 1, 0, 1};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 2, 1, 0, 1};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 2, 1, 0, 1};
    vecs[5]  = '{2'b00, 1'b1, 1'b0, 2, 1, 0, 1};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 1, 0, 1, 1};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 1, 0, 0, 1};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 1, 0, 0, 1};
    vecs[9]  = '{2'b00, 1'b0, 1'b0, 1, 1, 0, 1};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 1, 1, 0, 1};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 1, 1, 0, 1};
    vecs[12] = '{2'b00, 1'b1, 1'b0, 1, 1, 0, 1};
    vecs[13] = '{2'b00, 1'b0, 1'b0, 0, 0, 1, 1};
    vecs[14] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 1};
    vecs[15] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[16] = '{2'b11, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[17] = '{2'b00, 1'b0, 1'b1, 0, 0, 0, 0};
    vecs[18] = '{2'b00, 1'b1, 1'b0, 0, 0, 0, 0};
    vecs[19] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[20] = '{2'b00, 1'b0, 1'b0, 0, 0, 0, 0};

    // ---- vector table (basic payout, ignored codes/clears/edges in IDLE)
    do_reset();
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("vec%0d_owed", i), owed, vecs[i].e_owed);
      chk($sformatf("vec%0d_fire", i), hopper_fire, vecs[i].e_fire);
      chk($sformatf("vec%0d_paid", i), paid, vecs[i].e_paid);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_jam", i), jam, 0);
      change     = vecs[i].chg;
      coin_sense = vecs[i].sense;
      fault_clr  = vecs[i].fclr;
      tick();
    end
`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
    chk("idle_spurious_cnt", spurious_cnt, 1);
`endif
    chk("vec_overflow", overflow, 0);

    // ---- retries to jam, then clear and pay
    do_reset();
    change = 2'b01;
    tick();
    change = 2'b00;
    jam_at = -1;
    prev_fire = 1'b0;
    rises.delete();
    falls.delete();
    for (int k = 0; k < 400 && jam_at < 0; k++) begin
      if (hopper_fire && !prev_fire) rises.push_back(cyc);
      if (!hopper_fire && prev_fire) falls.push_back(cyc);
      prev_fire = hopper_fire;
      if (jam) jam_at = cyc;
      else tick();
    end
    chk("jam_reached", jam, 1);
    chk("fire_pulse_count", rises.size(), 3);
    chk("fire_fall_count", falls.size(), 3);
    if (rises.size() == 3 && falls.size() == 3) begin
      chk("first_fire_cycle", rises[0], 2);
      for (int k = 0; k < 3; k++) chk($sformatf("fire_len%0d", k), falls[k] - rises[k], 4);
      for (int k = 0; k < 2; k++) chk($sformatf("wait_len%0d", k), rises[k+1] - falls[k], 64);
      chk("last_wait_len", jam_at - falls[2], 64);
    end
    chk("jam_owed", owed, 1);
    fire_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (hopper_fire) fire_seen++;
      tick();
    end
    chk("jam_no_fire", fire_seen, 0);
    chk("jam_sticky", jam, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("jam_cleared", jam, 0);
    wait_fire("refire_after_clr");
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    chk("clr_paid", paid, 1);
    chk("clr_owed", owed, 0);
    chk("clr_jam", jam, 0);

    // ---- accepted edge and request in the same WAIT cycle
    do_reset();
    change = 2'b01;
    tick();
    change = 2'b00;
    wait_fire("t3_fire");
    for (int k = 0; k < 8 && hopper_fire; k++) tick();
    repeat (3) tick();
    change = 2'b01;
    coin_sense = 1'b1;
    tick();
    change = 2'b00;
    coin_sense = 1'b0;
    chk("same_cycle_owed", owed, 1);
    chk("same_cycle_paid", paid, 1);
    chk("same_cycle_fire", hopper_fire, 0);
    tick();
    tick();
    chk("gap_no_fire", hopper_fire, 0);
    tick();
    chk("refire_after_gap", hopper_fire, 1);
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    chk("drain_paid", paid, 1);
    chk("drain_owed", owed, 0);

    // ---- saturation while jammed
    do_reset();
    change = 2'b01;
    tick();
    change = 2'b00;
    wait_jam("sat_jam");
    for (int k = 0; k < 6; k++) begin
      change = 2'b10;
      tick();
    end
    change = 2'b01;
    tick();
    change = 2'b00;
    tick();
    chk("sat_owed14", owed, 14);
    chk("sat_ovf_before", overflow, 0);
    change = 2'b10;
    tick();
    change = 2'b00;
    chk("sat_owed15", owed, 15);
    chk("sat_ovf_set", overflow, 1);
    change = 2'b01;
    tick();
    change = 2'b00;
    tick();
    chk("sat_owed_hold", owed, 15);
    chk("sat_ovf_sticky", overflow, 1);
    chk("sat_no_fire", hopper_fire, 0);

    // ---- reset in mid-FIRE, sensor held high through release
    do_reset();
    change = 2'b01;
    tick();
    change = 2'b00;
    wait_fire("rst_fire");
    tick();
    tick();
    chk("rst_third_fire", hopper_fire, 1);
    rst = 1'b1;
    coin_sense = 1'b1;
    tick();
    chk("rst_fire_off", hopper_fire, 0);
    chk("rst_owed", owed, 0);
    chk("rst_jam", jam, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paid", paid, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    change = 2'b01;
    tick();
    change = 2'b00;
    paid_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (paid) paid_seen++;
      tick();
    end
    chk("held_sense_no_paid", paid_seen, 0);
    chk("held_sense_owed", owed, 1);
`ifdef CHANGE_DISPENSER_SPURIOUS_CNT_EN
    chk("held_sense_no_spurious", spurious_cnt, 0);
`endif
    coin_sense = 1'b0;
    tick();
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    chk("wait_edge_paid", paid, 1);
    chk("wait_edge_owed", owed, 0);

    // ---- random requests against a coin-balance model; hopper answers during firing
    do_reset();
    r_owed = 0; r_ovf = 0; exp_paid = 0;
    hi_cnt = 0; target = 0; misses = 0; answered = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      chk("rnd_owed", owed, r_owed);
      chk("rnd_paid", paid, exp_paid);
      chk("rnd_ovf", overflow, r_ovf);
      chk("rnd_jam", jam, 0);
      change = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      add = (change == 2'b01) ? 1 : (change == 2'b10) ? 2 : 0;
      dec = 0;
      if (coin_sense) begin
        coin_sense = 1'b0;
      end else if (hopper_fire) begin
        if (hi_cnt == 0) target = (misses >= 2) ? $urandom_range(0, 3) : $urandom_range(0, 4);
        if (hi_cnt == target) begin
          coin_sense = 1'b1;
          dec = 1;
          misses = 0;
          answered = 1'b1;
        end
        hi_cnt++;
      end else begin
        if (hi_cnt > 0 && !answered) misses++;
        hi_cnt = 0;
        answered = 1'b0;
      end
      r_owed = r_owed + add - dec;
      if (r_owed > OWED_TOP) begin
        r_owed = OWED_TOP;
        r_ovf = 1;
      end
      exp_paid = dec;
      tick();
    end
    change = 2'b00;
    coin_sense = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
